// File: rtl/intr_ctrl_if.sv
// Port bundle for intr_ctrl: interrupt sources, per-port config and ack in;
// registered vector request, pending and timeout status out.
interface intr_ctrl_if #(
  parameter int PORTS = 8
);
  localparam int NUM_W = $clog2(PORTS);

  logic [PORTS-1:0] intr;
  logic [PORTS-1:0] intr_edge_mode;
  logic [PORTS-1:0] intr_mask;
  logic             intr_vec_ack;
  logic             intr_vec_req;
  logic [NUM_W-1:0] intr_num;
  logic [PORTS-1:0] intr_onehot;
  logic [PORTS-1:0] intr_pending;
  logic             intr_timeout;

  modport master (
    output intr, intr_edge_mode, intr_mask, intr_vec_ack,
    input  intr_vec_req, intr_num, intr_onehot, intr_pending, intr_timeout
  );

  modport slave (
    input  intr, intr_edge_mode, intr_mask, intr_vec_ack,
    output intr_vec_req, intr_num, intr_onehot, intr_pending, intr_timeout
  );
endinterface

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: edge/level pending capture, one vector
// request at a time, idle gap after each ack. Optional request timeout with INTR_CTRL_TIMEOUT_EN.
module intr_ctrl #(
  parameter int PORTS             = 8,
  parameter int LSB_HIGH_PRIORITY = 1,
  parameter int GAP_CYCLES        = 2,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        rst,
  intr_ctrl_if.slave  bus
);

  localparam int NUM_W   = $clog2(PORTS);
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [PORTS-1:0] intr_last;
  logic [PORTS-1:0] pending_q, pending_nxt;
  logic [PORTS-1:0] edge_det, cand, ack_clr;
  logic [PORTS-1:0] sel_onehot;
  logic [NUM_W-1:0] sel_num;
  logic             sel_valid;
  logic             req_q, req_nxt;
  logic [NUM_W-1:0] num_q, num_nxt;
  logic [PORTS-1:0] onehot_q, onehot_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
`ifdef INTR_CTRL_TIMEOUT_EN
  logic             timeout_q, timeout_nxt;
`endif

  // Masked ports keep their pending bit but are hidden from selection.
  always_comb begin
    edge_det  = bus.intr & ~intr_last;
    cand      = pending_q & ~bus.intr_mask;
    sel_valid = |cand;
    sel_num   = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--)
        if (cand[i]) sel_num = NUM_W'(i);
    end else begin
      for (int i = 0; i < PORTS; i++)
        if (cand[i]) sel_num = NUM_W'(i);
    end
    sel_onehot = PORTS'(1) << sel_num;
  end

  always_comb begin
    state_nxt  = state;
    req_nxt    = req_q;
    num_nxt    = num_q;
    onehot_nxt = onehot_q;
    cnt_nxt    = cnt;
    ack_clr    = '0;
`ifdef INTR_CTRL_TIMEOUT_EN
    timeout_nxt = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (sel_valid) begin
          state_nxt  = S_REQ;
          req_nxt    = 1'b1;
          num_nxt    = sel_num;
          onehot_nxt = sel_onehot;
`ifdef INTR_CTRL_TIMEOUT_EN
          cnt_nxt    = CNT_W'(TIMEOUT_CYCLES);
`endif
        end
      end
      S_REQ: begin
        if (bus.intr_vec_ack) begin
          state_nxt  = S_GAP;
          req_nxt    = 1'b0;
          num_nxt    = '0;
          onehot_nxt = '0;
          ack_clr    = onehot_q;
          cnt_nxt    = CNT_W'(GAP_CYCLES);
        end
`ifdef INTR_CTRL_TIMEOUT_EN
        // Timed-out request is dropped but its pending bit is kept for a retry.
        else if (cnt == CNT_W'(1)) begin
          state_nxt   = S_GAP;
          req_nxt     = 1'b0;
          num_nxt     = '0;
          onehot_nxt  = '0;
          timeout_nxt = 1'b1;
          cnt_nxt     = CNT_W'(GAP_CYCLES);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
`endif
      end
      S_GAP: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A new edge on the port being acknowledged wins over the clear.
  assign pending_nxt = (bus.intr_edge_mode & (edge_det | (pending_q & ~ack_clr)))
                     | (~bus.intr_edge_mode & bus.intr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      intr_last <= '0;
      pending_q <= '0;
      req_q     <= 1'b0;
      num_q     <= '0;
      onehot_q  <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      intr_last <= bus.intr;
      pending_q <= pending_nxt;
      req_q     <= req_nxt;
      num_q     <= num_nxt;
      onehot_q  <= onehot_nxt;
      cnt       <= cnt_nxt;
    end
  end

`ifdef INTR_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_nxt;
  end
  assign bus.intr_timeout = timeout_q;
`else
  assign bus.intr_timeout = 1'b0;
`endif

  assign bus.intr_vec_req = req_q;
  assign bus.intr_num     = num_q;
  assign bus.intr_onehot  = onehot_q;
  assign bus.intr_pending = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed scenarios plus random traffic,
// checked against a cycle-indexed behavioural model of pending/grant rules.
module tb_intr_ctrl;
  localparam int P   = 8;
  localparam int LSB = 1;
  localparam int GAP = 2;
  localparam int TO  = 4;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  intr_ctrl_if #(.PORTS(P)) bus ();

  intr_ctrl #(
    .PORTS(P), .LSB_HIGH_PRIORITY(LSB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [P-1:0] c);
    int w = -1;
    for (int i = 0; i < P; i++)
      if (c[i] && (w < 0 || LSB == 0)) w = i;
    return w;
  endfunction

  // Reference model: pending per the capture rules; a grant may start at
  // edge t only when no request is open and t has reached next_ok.
  int          t_edge, m_port, m_start, m_next_ok;
  logic [P-1:0] m_pend, m_last, m_edges, m_cand;
  bit          m_req, m_to, m_clr_en;
  int          exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_edge = 0; m_pend = '0; m_last = '0; m_req = 0; m_to = 0;
      m_next_ok = 0; m_port = 0; m_start = 0;
      exp_q.delete();
    end else begin
      t_edge++;
      m_edges  = bus.intr & ~m_last;
      m_cand   = m_pend & ~bus.intr_mask;
      m_clr_en = 0;
      m_to     = 0;
      if (m_req) begin
        if (bus.intr_vec_ack) begin
          m_req = 0; m_clr_en = 1; m_next_ok = t_edge + GAP + 1;
        end
`ifdef INTR_CTRL_TIMEOUT_EN
        else if (t_edge - m_start == TO) begin
          m_req = 0; m_to = 1; m_next_ok = t_edge + GAP + 1;
        end
`endif
      end else if (t_edge >= m_next_ok && m_cand != '0) begin
        m_port = pick(m_cand); m_req = 1; m_start = t_edge;
        exp_q.push_back(m_port);
      end
      for (int i = 0; i < P; i++) begin
        if (!bus.intr_edge_mode[i])   m_pend[i] = bus.intr[i];
        else if (m_edges[i])           m_pend[i] = 1'b1;
        else if (m_clr_en && i == m_port) m_pend[i] = 1'b0;
      end
      m_last = bus.intr;
    end
  end

  bit prev_req;
  int cur_num;

  always @(negedge clk) begin
    if (rst) prev_req = 0;
    else begin
      chk("pending", bus.intr_pending, m_pend);
      chk("vec_req", bus.intr_vec_req, m_req);
      chk("timeout", bus.intr_timeout, m_to);
      if (bus.intr_vec_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++; cur_num = 0;
          $display("FAIL unexpected_req: got num %0d, expected no request", bus.intr_num);
        end else begin
          cur_num = exp_q.pop_front();
          chk("num", bus.intr_num, cur_num);
          chk("onehot", bus.intr_onehot, 32'(1) << cur_num);
        end
      end else if (bus.intr_vec_req) begin
        chk("num_hold", bus.intr_num, cur_num);
        chk("onehot_hold", bus.intr_onehot, 32'(1) << cur_num);
      end else begin
        chk("num_idle", bus.intr_num, 0);
        chk("onehot_idle", bus.intr_onehot, 0);
      end
      prev_req = bus.intr_vec_req;
    end
  end

  task automatic wait_req(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.intr_vec_req && cyc < 100);
    chk("req_wait", bus.intr_vec_req, 1);
  endtask

  task automatic ack_after(input int d);
    repeat (d) @(negedge clk);
    bus.intr_vec_ack = 1'b1;
    @(negedge clk);
    bus.intr_vec_ack = 1'b0;
  endtask

  task automatic pulse(input logic [P-1:0] v);
    @(negedge clk); bus.intr = v;
    @(negedge clk); bus.intr = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1;
    bus.intr = '0; bus.intr_edge_mode = '1; bus.intr_mask = '0; bus.intr_vec_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", bus.intr_vec_req, 0);
    chk("rst_pending", bus.intr_pending, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single edge source, ack three cycles after the request
    pulse(8'h04);
    wait_req(cyc);
    chk("d1_num", bus.intr_num, 2);
    chk("d1_onehot", bus.intr_onehot, 8'h04);
    chk("d1_pend", bus.intr_pending, 8'h04);
    ack_after(3);
    chk("d1_pend_clr", bus.intr_pending, 8'h00);

    // simultaneous edges: lowest wins, next grant exactly GAP+1 after ack
    pulse(8'h90);
    wait_req(cyc);
    chk("d2_first", bus.intr_num, 4);
    ack_after(0);
    wait_req(cyc);
    chk("d2_gap", cyc, GAP + 1);
    chk("d2_second", bus.intr_num, 7);
    ack_after(0);

    // masked source stays pending but is not granted until unmasked
    bus.intr_mask = 8'h01;
    pulse(8'h01);
    repeat (4) @(negedge clk);
    chk("d3_no_req", bus.intr_vec_req, 0);
    chk("d3_pend", bus.intr_pending, 8'h01);
    bus.intr_mask = 8'h00;
    wait_req(cyc);
    chk("d3_num", bus.intr_num, 0);
    ack_after(1);

    // level source survives ack and is re-granted after the gap
    bus.intr_edge_mode = 8'hF7;
    @(negedge clk); bus.intr = 8'h08;
    wait_req(cyc);
    chk("d4_num", bus.intr_num, 3);
    ack_after(0);
    chk("d4_pend_kept", bus.intr_pending, 8'h08);
    wait_req(cyc);
    chk("d4_regap", cyc, GAP + 1);
    chk("d4_renum", bus.intr_num, 3);
    ack_after(0);
    bus.intr = '0;
    repeat (5) @(negedge clk);
    chk("d4_pend_drop", bus.intr_pending, 8'h00);
    chk("d4_no_req", bus.intr_vec_req, 0);
    bus.intr_edge_mode = '1;

    // asynchronous reset in the middle of a request
    pulse(8'h20);
    wait_req(cyc);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("d5_req", bus.intr_vec_req, 0);
    chk("d5_num", bus.intr_num, 0);
    chk("d5_onehot", bus.intr_onehot, 0);
    chk("d5_pend", bus.intr_pending, 0);
    chk("d5_tmo", bus.intr_timeout, 0);
    bus.intr_vec_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); bus.intr_vec_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("d5_after", bus.intr_vec_req, 0);

`ifdef INTR_CTRL_TIMEOUT_EN
    // unacknowledged request times out, pending kept, retried after gap
    pulse(8'h02);
    wait_req(cyc);
    cyc = 1;
    while (cyc < 50) begin
      @(negedge clk);
      if (!bus.intr_vec_req) break;
      cyc++;
    end
    chk("d6_len", cyc, TO);
    chk("d6_pend", bus.intr_pending, 8'h02);
    wait_req(cyc);
    chk("d6_retry", bus.intr_num, 1);
    ack_after(0);
`endif

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.intr = P'($urandom);
      if ($urandom_range(0, 15) == 0) bus.intr_mask = P'($urandom);
      if ($urandom_range(0, 31) == 0) bus.intr_edge_mode = P'($urandom);
      bus.intr_vec_ack = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    bus.intr = '0; bus.intr_mask = '0; bus.intr_vec_ack = 1'b1;
    repeat (40) @(negedge clk);
    bus.intr_vec_ack = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
